alu_operand_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the MIPS ALU. It accepts a decoded instruction through a valid/ready handshake and resolves operand forwarding from EX/MEM and MEM/WB. It selects immediate or shift-amount operands, then registers sr/tg/ALUop for the ALU. It also handles stall, load-use bubble and flush.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/fwd_mux.sv | 35 +++
 rtl/alu_operand_stage.sv | 201 ++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, ALU opcodes,
// target-operand selector codes and the operand stage state type.
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REGW_DEFAULT = 5;

  localparam logic [3:0] ALUOP_SLL  = 4'd0;
  localparam logic [3:0] ALUOP_SRA  = 4'd1;
  localparam logic [3:0] ALUOP_SRL  = 4'd2;
  localparam logic [3:0] ALUOP_MUL  = 4'd3;
  localparam logic [3:0] ALUOP_DIV  = 4'd4;
  localparam logic [3:0] ALUOP_ADD  = 4'd5;
  localparam logic [3:0] ALUOP_SUB  = 4'd6;
  localparam logic [3:0] ALUOP_AND  = 4'd7;
  localparam logic [3:0] ALUOP_OR   = 4'd8;
  localparam logic [3:0] ALUOP_XOR  = 4'd9;
  localparam logic [3:0] ALUOP_NOR  = 4'd10;
  localparam logic [3:0] ALUOP_SLT  = 4'd11;
  localparam logic [3:0] ALUOP_SLTU = 4'd12;

  localparam logic [2:0] SRC_RT       = 3'd0;
  localparam logic [2:0] SRC_SEXT     = 3'd1;
  localparam logic [2:0] SRC_ZEXT     = 3'd2;
  localparam logic [2:0] SRC_LUI      = 3'd3;
  localparam logic [2:0] SRC_SHAMT    = 3'd4;
  localparam logic [2:0] SRC_RS_SHIFT = 3'd5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Shift ops take the shifted value from rt, everything else from rs.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op <= ALUOP_SRL);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding resolver: newest non-load producer wins, register 0
// always reads as zero.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int REGW = REGW_DEFAULT
) (
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] rf_val,
  input  logic            exm_wen,
  input  logic            exm_is_load,
  input  logic [REGW-1:0] exm_dst,
  input  logic [XLEN-1:0] exm_val,
  input  logic            mwb_wen,
  input  logic [REGW-1:0] mwb_dst,
  input  logic [XLEN-1:0] mwb_val,
  output logic [XLEN-1:0] val
);

  // Priority select: zero register, EX/MEM, MEM/WB, register file.
  always_comb begin
    val = {XLEN{1'b0}};
    if (idx == {REGW{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else if (exm_wen && !exm_is_load && (exm_dst == idx)) begin
      val = exm_val;
    end else if (mwb_wen && (mwb_dst == idx)) begin
      val = mwb_val;
    end else begin
      val = rf_val;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage in front of the ALU: resolves forwarding, picks the target
// operand and holds sr/tg/ALUop in a one-entry valid/ready register.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int REGW = REGW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rs_idx,
  input  logic [REGW-1:0] in_rt_idx,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  input  logic [15:0]     in_imm,
  input  logic [4:0]      in_shamt,
  input  logic [2:0]      in_src_sel,
  input  logic            in_uses_rs,
  input  logic            in_uses_rt,
  input  logic [3:0]      in_aluop,
  input  logic [REGW-1:0] in_dst,
  input  logic            in_wen,
  input  logic            exm_wen,
  input  logic            exm_is_load,
  input  logic [REGW-1:0] exm_dst,
  input  logic [XLEN-1:0] exm_val,
  input  logic            mwb_wen,
  input  logic [REGW-1:0] mwb_dst,
  input  logic [XLEN-1:0] mwb_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] sr,
  output logic [XLEN-1:0] tg,
  output logic [3:0]      ALUop,
  output logic [REGW-1:0] out_dst,
  output logic            out_wen
);

  stage_state_e state_r, state_next_s;

  logic            out_valid_s, in_ready_s, load_use_s, capture_s, hold_s;
  logic [XLEN-1:0] rs_fwd_s, rt_fwd_s, sr_next_s, tg_next_s, tg_refresh_s;
  logic            shift_op_s;
  logic [REGW-1:0] sr_idx_next_s, tg_idx_next_s;
  logic            sr_use_next_s, tg_use_next_s, tg_narrow_next_s;
  logic            mwb_sr_hit_s, mwb_tg_hit_s;

  logic [XLEN-1:0] sr_r, tg_r;
  logic [3:0]      aluop_r;
  logic [REGW-1:0] dst_r, sr_idx_r, tg_idx_r;
  logic            wen_r, sr_use_r, tg_use_r, tg_narrow_r;

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_rs_fwd (
    .idx(in_rs_idx), .rf_val(in_rs_val),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_dst(exm_dst), .exm_val(exm_val),
    .mwb_wen(mwb_wen), .mwb_dst(mwb_dst), .mwb_val(mwb_val),
    .val(rs_fwd_s)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_rt_fwd (
    .idx(in_rt_idx), .rf_val(in_rt_val),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_dst(exm_dst), .exm_val(exm_val),
    .mwb_wen(mwb_wen), .mwb_dst(mwb_dst), .mwb_val(mwb_val),
    .val(rt_fwd_s)
  );

  // A load still in EX/MEM cannot supply its result yet.
  always_comb begin
    load_use_s = in_valid && exm_wen && exm_is_load && (exm_dst != {REGW{1'b0}}) &&
                 ((in_uses_rs && (exm_dst == in_rs_idx)) ||
                  (in_uses_rt && (exm_dst == in_rt_idx)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: flush beats capture, capture beats drain.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else if (capture_s) begin
      state_next_s = ST_FULL;
    end else if (out_ready) begin
      state_next_s = ST_EMPTY;
    end else begin
      state_next_s = state_r;
    end
  end

  // Handshake outputs derived from the state register.
  always_comb begin
    out_valid_s = (state_r == ST_FULL);
    in_ready_s  = (!out_valid_s || out_ready) && !load_use_s && !flush;
    capture_s   = in_valid && in_ready_s;
    hold_s      = out_valid_s && !out_ready && !flush;
  end

  // Operand selection plus bookkeeping of which register feeds each operand.
  always_comb begin
    shift_op_s       = is_shift_op(in_aluop);
    tg_idx_next_s    = {REGW{1'b0}};
    tg_use_next_s    = 1'b0;
    tg_narrow_next_s = 1'b0;
    if (shift_op_s) begin
      sr_next_s     = rt_fwd_s;
      sr_idx_next_s = in_rt_idx;
      sr_use_next_s = in_uses_rt;
    end else begin
      sr_next_s     = rs_fwd_s;
      sr_idx_next_s = in_rs_idx;
      sr_use_next_s = in_uses_rs;
    end
    case (in_src_sel)
      SRC_RT: begin
        tg_next_s     = rt_fwd_s;
        tg_idx_next_s = in_rt_idx;
        tg_use_next_s = in_uses_rt;
      end
      SRC_SEXT:  tg_next_s = XLEN'($signed(in_imm));
      SRC_ZEXT:  tg_next_s = XLEN'(in_imm);
      SRC_LUI:   tg_next_s = XLEN'(in_imm) << 16;
      SRC_SHAMT: tg_next_s = XLEN'(in_shamt);
      SRC_RS_SHIFT: begin
        tg_next_s        = XLEN'(rs_fwd_s[4:0]);
        tg_idx_next_s    = in_rs_idx;
        tg_use_next_s    = in_uses_rs;
        tg_narrow_next_s = 1'b1;
      end
      default:   tg_next_s = {XLEN{1'b0}};
    endcase
  end

  // A held operand must not miss a writeback that retires while we stall.
  always_comb begin
    mwb_sr_hit_s = hold_s && mwb_wen && (mwb_dst != {REGW{1'b0}}) && sr_use_r &&
                   (mwb_dst == sr_idx_r);
    mwb_tg_hit_s = hold_s && mwb_wen && (mwb_dst != {REGW{1'b0}}) && tg_use_r &&
                   (mwb_dst == tg_idx_r);
    if (tg_narrow_r) begin
      tg_refresh_s = XLEN'(mwb_val[4:0]);
    end else begin
      tg_refresh_s = mwb_val;
    end
  end

  // Output/data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r        <= {XLEN{1'b0}};
      tg_r        <= {XLEN{1'b0}};
      aluop_r     <= 4'd0;
      dst_r       <= {REGW{1'b0}};
      wen_r       <= 1'b0;
      sr_idx_r    <= {REGW{1'b0}};
      tg_idx_r    <= {REGW{1'b0}};
      sr_use_r    <= 1'b0;
      tg_use_r    <= 1'b0;
      tg_narrow_r <= 1'b0;
    end else if (capture_s) begin
      sr_r        <= sr_next_s;
      tg_r        <= tg_next_s;
      aluop_r     <= in_aluop;
      dst_r       <= in_dst;
      wen_r       <= in_wen;
      sr_idx_r    <= sr_idx_next_s;
      tg_idx_r    <= tg_idx_next_s;
      sr_use_r    <= sr_use_next_s;
      tg_use_r    <= tg_use_next_s;
      tg_narrow_r <= tg_narrow_next_s;
    end else begin
      if (flush) begin
        wen_r <= 1'b0;
      end
      if (mwb_sr_hit_s) begin
        sr_r <= mwb_val;
      end
      if (mwb_tg_hit_s) begin
        tg_r <= tg_refresh_s;
      end
    end
  end

  assign out_valid = out_valid_s;
  assign in_ready  = in_ready_s;
  assign sr        = sr_r;
  assign tg        = tg_r;
  assign ALUop     = aluop_r;
  assign out_dst   = dst_r;
  assign out_wen   = wen_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios with constant
// expectations followed by random traffic checked against a behavioural model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs_idx, in_rt_idx, in_shamt, in_dst;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic [2:0]  in_src_sel;
  logic        in_uses_rs, in_uses_rt, in_wen;
  logic [3:0]  in_aluop;
  logic        exm_wen, exm_is_load, mwb_wen, flush;
  logic [4:0]  exm_dst, mwb_dst;
  logic [31:0] exm_val, mwb_val;
  logic        out_valid, out_ready, out_wen;
  logic [31:0] sr, tg;
  logic [3:0]  ALUop;
  logic [4:0]  out_dst;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_src_sel(in_src_sel),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_aluop(in_aluop),
    .in_dst(in_dst), .in_wen(in_wen),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_dst(exm_dst), .exm_val(exm_val),
    .mwb_wen(mwb_wen), .mwb_dst(mwb_dst), .mwb_val(mwb_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .sr(sr), .tg(tg), .ALUop(ALUop),
    .out_dst(out_dst), .out_wen(out_wen)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what the ALU should currently see.
  logic        m_valid, m_wen, m_tg_low5, exp_ready, ready_seen;
  logic [31:0] m_sr, m_tg;
  logic [3:0]  m_op;
  logic [4:0]  m_dst, m_sr_src, m_tg_src;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (exm_wen && !exm_is_load && exm_dst == idx) return exm_val;
    if (mwb_wen && mwb_dst == idx) return mwb_val;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_wen = 1'b0; m_sr = 32'd0; m_tg = 32'd0; m_op = 4'd0; m_dst = 5'd0;
    m_sr_src = 5'd0; m_tg_src = 5'd0; m_tg_low5 = 1'b0;
  endtask

  task automatic model_step();
    logic lu, shift;
    logic [31:0] a, b;
    lu = in_valid && exm_wen && exm_is_load && exm_dst != 5'd0 &&
         ((in_uses_rs && exm_dst == in_rs_idx) || (in_uses_rt && exm_dst == in_rt_idx));
    exp_ready = (!m_valid || out_ready) && !lu && !flush;
    if (flush) begin
      m_valid = 1'b0; m_wen = 1'b0;
    end else if (in_valid && exp_ready) begin
      a = fwd(in_rs_idx, in_rs_val);
      b = fwd(in_rt_idx, in_rt_val);
      shift = (in_aluop <= 4'd2);
      m_valid = 1'b1; m_op = in_aluop; m_dst = in_dst; m_wen = in_wen;
      m_sr = shift ? b : a;
      if (shift) m_sr_src = in_uses_rt ? in_rt_idx : 5'd0;
      else       m_sr_src = in_uses_rs ? in_rs_idx : 5'd0;
      m_tg_src = 5'd0; m_tg_low5 = 1'b0;
      case (in_src_sel)
        3'd0: begin m_tg = b; if (in_uses_rt) m_tg_src = in_rt_idx; end
        3'd1: m_tg = {{16{in_imm[15]}}, in_imm};
        3'd2: m_tg = {16'h0000, in_imm};
        3'd3: m_tg = {in_imm, 16'h0000};
        3'd4: m_tg = {27'd0, in_shamt};
        3'd5: begin m_tg = {27'd0, a[4:0]}; m_tg_low5 = 1'b1; if (in_uses_rs) m_tg_src = in_rs_idx; end
        default: m_tg = 32'd0;
      endcase
    end else if (m_valid && !out_ready) begin
      if (mwb_wen && mwb_dst != 5'd0 && mwb_dst == m_sr_src) m_sr = mwb_val;
      if (mwb_wen && mwb_dst != 5'd0 && mwb_dst == m_tg_src)
        m_tg = m_tg_low5 ? {27'd0, mwb_val[4:0]} : mwb_val;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: sample in_ready mid-cycle, advance the model, settle after the edge.
  task automatic tick();
    @(negedge clk);
    ready_seen = in_ready;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rs_idx = 5'd0; in_rt_idx = 5'd0; in_rs_val = 32'd0; in_rt_val = 32'd0;
    in_imm = 16'd0; in_shamt = 5'd0; in_src_sel = 3'd0; in_uses_rs = 1'b0; in_uses_rt = 1'b0;
    in_aluop = 4'd0; in_dst = 5'd0; in_wen = 1'b0;
    exm_wen = 1'b0; exm_is_load = 1'b0; exm_dst = 5'd0; exm_val = 32'd0;
    mwb_wen = 1'b0; mwb_dst = 5'd0; mwb_val = 32'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_instr(input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [31:0] rs_v,
                           input logic [31:0] rt_v, input logic [15:0] imm, input logic [4:0] sh,
                           input logic [2:0] src, input logic [3:0] op);
    in_rs_idx = rs_i; in_rt_idx = rt_i; in_rs_val = rs_v; in_rt_val = rt_v; in_imm = imm;
    in_shamt = sh; in_src_sel = src; in_aluop = op; in_uses_rs = 1'b1; in_uses_rt = 1'b1;
    in_dst = 5'd3; in_wen = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if ({sr, tg} !== 64'd0) begin errors++; $display("FAIL reset_data got sr=%h tg=%h exp=0", sr, tg); end
    checks++; if ({ALUop, out_dst, out_wen} !== 10'd0) begin errors++; $display("FAIL reset_ctl got op=%0d dst=%0d wen=%0b exp=0", ALUop, out_dst, out_wen); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    idle_inputs();
    set_instr(5'd1, 5'd2, 32'd5, 32'd7, 16'h0000, 5'd0, 3'd0, 4'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL add_ready got=%0b exp=1", ready_seen); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    checks++; if (sr !== 32'd5) begin errors++; $display("FAIL add_sr got=%h exp=5", sr); end
    checks++; if (tg !== 32'd7) begin errors++; $display("FAIL add_tg got=%h exp=7", tg); end
    checks++; if ({ALUop, out_dst, out_wen} !== {4'd5, 5'd3, 1'b1}) begin errors++; $display("FAIL add_ctl got op=%0d dst=%0d wen=%0b exp 5/3/1", ALUop, out_dst, out_wen); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%0b exp=0", out_valid); end
  endtask

  // Back-to-back captures with out_ready=1, one forwarding case per cycle.
  task automatic test_forward();
    logic [31:0] exp_tg;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      set_instr(5'd1, 5'd2, 32'd5, 32'd7, 16'h0000, 5'd0, 3'd0, 4'd5);
      exm_wen = 1'b0; exm_is_load = 1'b0; mwb_wen = 1'b0;
      case (i)
        0: begin exm_wen = 1'b1; exm_dst = 5'd2; exm_val = 32'h100; exp_tg = 32'h100; end
        1: begin exm_wen = 1'b1; exm_dst = 5'd2; exm_val = 32'h100;
                 mwb_wen = 1'b1; mwb_dst = 5'd2; mwb_val = 32'h200; exp_tg = 32'h100; end
        2: begin mwb_wen = 1'b1; mwb_dst = 5'd2; mwb_val = 32'h200; exp_tg = 32'h200; end
        3: begin in_rt_idx = 5'd0; exm_wen = 1'b1; exm_dst = 5'd0; exm_val = 32'hFFFF_FFFF;
                 mwb_wen = 1'b1; mwb_dst = 5'd0; mwb_val = 32'hFFFF_FFFF; exp_tg = 32'd0; end
        default: begin in_uses_rt = 1'b0; exm_wen = 1'b1; exm_is_load = 1'b1; exm_dst = 5'd2;
                 exm_val = 32'h300; mwb_wen = 1'b1; mwb_dst = 5'd2; mwb_val = 32'h200; exp_tg = 32'h200; end
      endcase
      in_valid = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd%0d_valid got=%0b exp=1", i, out_valid); end
      checks++; if (tg !== exp_tg) begin errors++; $display("FAIL fwd%0d_tg got=%h exp=%h", i, tg, exp_tg); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_immediates();
    logic [31:0] exp_tg;
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      set_instr(5'd1, 5'd2, 32'd5, 32'd7, 16'h8001, 5'd0, 3'(i), 4'd8);
      case (i)
        1: exp_tg = 32'hFFFF_8001;
        2: exp_tg = 32'h0000_8001;
        default: exp_tg = 32'h8001_0000;
      endcase
      in_valid = 1'b1;
      tick();
      checks++; if (tg !== exp_tg) begin errors++; $display("FAIL imm_src%0d got=%h exp=%h", i, tg, exp_tg); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_shift();
    idle_inputs();
    set_instr(5'd0, 5'd1, 32'd0, 32'd1, 16'h0000, 5'd31, 3'd4, 4'd0);
    in_uses_rs = 1'b0;
    in_valid = 1'b1;
    tick();
    checks++; if ({sr, tg} !== {32'd1, 32'h1F}) begin errors++; $display("FAIL sll got sr=%h tg=%h exp sr=1 tg=1f", sr, tg); end
    set_instr(5'd4, 5'd1, 32'h23, 32'h8000_0000, 16'h0000, 5'd0, 3'd5, 4'd1);
    tick();
    checks++; if ({sr, tg} !== {32'h8000_0000, 32'd3}) begin errors++; $display("FAIL srav got sr=%h tg=%h exp sr=80000000 tg=3", sr, tg); end
    checks++; if (ALUop !== 4'd1) begin errors++; $display("FAIL srav_op got=%0d exp=1", ALUop); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    set_instr(5'd1, 5'd2, 32'd5, 32'd7, 16'h0000, 5'd0, 3'd0, 4'd5);
    in_valid = 1'b1;
    tick();
    set_instr(5'd3, 5'd0, 32'hDEAD, 32'd0, 16'h0004, 5'd0, 3'd2, 4'd5);
    exm_wen = 1'b1; exm_is_load = 1'b1; exm_dst = 5'd3; exm_val = 32'h99;
    tick();
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL lu_ready got=%0b exp=0", ready_seen); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%0b exp=0", out_valid); end
    exm_wen = 1'b0; exm_is_load = 1'b0;
    mwb_wen = 1'b1; mwb_dst = 5'd3; mwb_val = 32'h55;
    tick();
    checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL lu_retry_ready got=%0b exp=1", ready_seen); end
    checks++; if ({out_valid, sr} !== {1'b1, 32'h55}) begin errors++; $display("FAIL lu_capture got v=%0b sr=%h exp v=1 sr=55", out_valid, sr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure_flush();
    idle_inputs();
    set_instr(5'd6, 5'd7, 32'h11, 32'h22, 16'h0000, 5'd0, 3'd0, 4'd6);
    in_dst = 5'd9;
    in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    set_instr(5'd1, 5'd2, 32'hAA, 32'hBB, 16'h1234, 5'd0, 3'd1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL hold%0d_ready got=%0b exp=0", i, ready_seen); end
      checks++; if ({out_valid, sr, tg, ALUop, out_dst} !== {1'b1, 32'h11, 32'h22, 4'd6, 5'd9}) begin
        errors++; $display("FAIL hold%0d_outputs got v=%0b sr=%h tg=%h op=%0d dst=%0d exp 1/11/22/6/9", i, out_valid, sr, tg, ALUop, out_dst); end
    end
    mwb_wen = 1'b1; mwb_dst = 5'd7; mwb_val = 32'h77;
    tick();
    checks++; if ({sr, tg} !== {32'h11, 32'h77}) begin errors++; $display("FAIL hold_refresh got sr=%h tg=%h exp sr=11 tg=77", sr, tg); end
    mwb_wen = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({out_valid, out_wen} !== 2'b00) begin errors++; $display("FAIL flush got v=%0b wen=%0b exp 0/0", out_valid, out_wen); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL refill_valid got=%0b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_wen, sr} !== 34'd0) begin errors++; $display("FAIL async_reset got v=%0b wen=%0b sr=%h exp 0", out_valid, out_wen, sr); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture got=%0b exp=0", out_valid); end
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] op;
    int r;
    for (int n = 0; n < 1500; n++) begin
      op = 4'($urandom_range(0, 12));
      r  = int'($urandom_range(0, 5));
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs_idx = 5'($urandom_range(0, 7)); in_rt_idx = 5'($urandom_range(0, 7));
      in_rs_val = $urandom; in_rt_val = $urandom; in_imm = 16'($urandom); in_shamt = 5'($urandom);
      in_aluop = op;
      if (op <= 4'd2) in_src_sel = 3'($urandom_range(4, 7));
      else            in_src_sel = (r < 4) ? 3'(r) : 3'(r + 2);
      in_uses_rs = 1'($urandom); in_uses_rt = 1'($urandom);
      in_dst = 5'($urandom); in_wen = 1'($urandom);
      exm_wen = 1'($urandom); exm_is_load = ($urandom_range(0, 3) == 0);
      exm_dst = 5'($urandom_range(0, 7)); exm_val = $urandom;
      mwb_wen = 1'($urandom); mwb_dst = 5'($urandom_range(0, 7)); mwb_val = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++; if (ready_seen !== exp_ready) begin errors++; $display("FAIL rnd%0d_ready got=%0b exp=%0b", n, ready_seen, exp_ready); end
      checks++;
      if ({out_valid, sr, tg, ALUop, out_dst, out_wen} !== {m_valid, m_sr, m_tg, m_op, m_dst, m_wen}) begin
        errors++;
        $display("FAIL rnd%0d_outputs got v=%0b sr=%h tg=%h op=%0d dst=%0d wen=%0b exp v=%0b sr=%h tg=%h op=%0d dst=%0d wen=%0b",
                 n, out_valid, sr, tg, ALUop, out_dst, out_wen, m_valid, m_sr, m_tg, m_op, m_dst, m_wen);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_immediates();
    test_shift();
    test_load_use();
    test_backpressure_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
